// File: rtl/wam_pkg.sv
// Shared keypad constants and key-code helpers for the
// whack-a-mole keypad path (scanner and decoder users).
package wam_pkg;

  localparam int KEY_W   = 4;
  localparam int KP_ROWS = 3;
  localparam int KP_COLS = 3;

  localparam logic [KEY_W-1:0] KEY_NONE = 4'b1111;

  typedef enum logic {
    ST_IDLE,
    ST_PRESSED
  } ks_state_e;

  function automatic logic [KEY_W-1:0] key_encode(
    input logic [1:0] row,
    input logic [1:0] col
  );
    return {row, col};
  endfunction

endpackage

// File: rtl/key_scanner_if.sv
// Keypad pins plus debounced key-code bundle.
// master = scanner side, slave = keypad/consumer side.
interface key_scanner_if;
  import wam_pkg::*;

  logic [KP_ROWS-1:0] row_in;
  logic [KP_COLS-1:0] col_out;
  logic [KEY_W-1:0]   key;
  logic               key_valid;
  logic               key_held;

  modport master (
    input  row_in,
    output col_out,
    output key,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key,
    input  key_valid,
    input  key_held
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer; resets to all-ones so idle
// pulled-up rows never look pressed after reset.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/key_scanner.sv
// 3x3 keypad column scanner with frame-level debounce,
// producing a held key code and a one-cycle press pulse.
module key_scanner
  import wam_pkg::*;
#(
  parameter int SCAN_DIV        = 4096,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic          clk,
  input  logic          resetn,
  key_scanner_if.master kp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = (DEBOUNCE_FRAMES > 1) ?
                      $clog2(DEBOUNCE_FRAMES) : 1;
  localparam int NK = KP_ROWS * KP_COLS;

  localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STAB_MAX  = SW'(DEBOUNCE_FRAMES - 1);
  localparam logic [1:0]    COL_LAST  = 2'(KP_COLS - 1);

  logic [KP_ROWS-1:0] rows_s;

  sync2 #(.W(KP_ROWS)) u_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d_i   (kp.row_in),
    .q_o   (rows_s)
  );

  logic [DW-1:0]    dwell_q, dwell_d;
  logic [1:0]       col_q, col_d;
  logic [NK-1:0]    frame_q, frame_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic             done_q;
  logic             sample;
  logic [3:0]       nbits;

  always_comb begin
    sample  = (dwell_q == DWELL_MAX);
    dwell_d = sample ? '0 : dwell_q + DW'(1);
    col_d   = col_q;
    if (sample)
      col_d = (col_q == COL_LAST) ? 2'd0 : col_q + 2'd1;
    frame_d = frame_q;
    for (int r = 0; r < KP_ROWS; r++)
      for (int c = 0; c < KP_COLS; c++)
        if (sample && col_q == 2'(c))
          frame_d[r*KP_COLS+c] = ~rows_s[r];
    // Ghosting or multi-press collapses to "no key".
    nbits  = '0;
    cand_d = KEY_NONE;
    for (int r = 0; r < KP_ROWS; r++)
      for (int c = 0; c < KP_COLS; c++)
        if (frame_d[r*KP_COLS+c]) begin
          nbits  = nbits + 4'd1;
          cand_d = key_encode(2'(r), 2'(c));
        end
    if (nbits != 4'd1)
      cand_d = KEY_NONE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dwell_q <= '0;
      col_q   <= '0;
      frame_q <= '0;
      cand_q  <= KEY_NONE;
      done_q  <= 1'b0;
    end else begin
      dwell_q <= dwell_d;
      col_q   <= col_d;
      frame_q <= frame_d;
      done_q  <= sample && (col_q == COL_LAST);
      if (sample && col_q == COL_LAST)
        cand_q <= cand_d;
    end
  end

  logic [SW-1:0]    stab_q, stab_d;
  logic [KEY_W-1:0] last_q, last_d;
  logic [KEY_W-1:0] key_q;
  logic             key_valid_q;
  logic             commit;
  ks_state_e        state_q;

  always_comb begin
    stab_d = stab_q;
    last_d = last_q;
    commit = 1'b0;
    if (done_q) begin
      if (cand_q == last_q) begin
        if (stab_q != STAB_MAX)
          stab_d = stab_q + SW'(1);
      end else begin
        stab_d = '0;
        last_d = cand_q;
      end
      commit = (stab_d == STAB_MAX) && (last_d != key_q);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      key_q       <= KEY_NONE;
      key_valid_q <= 1'b0;
      stab_q      <= '0;
      last_q      <= KEY_NONE;
    end else begin
      stab_q      <= stab_d;
      last_q      <= last_d;
      key_valid_q <= 1'b0;
      if (commit) begin
        key_q       <= last_d;
        key_valid_q <= (last_d != KEY_NONE);
        unique case (state_q)
          ST_IDLE:
            if (last_d != KEY_NONE)
              state_q <= ST_PRESSED;
          ST_PRESSED:
            if (last_d == KEY_NONE)
              state_q <= ST_IDLE;
          default:
            state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign kp.col_out   = ~(3'b001 << col_q);
  assign kp.key       = key_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = (state_q == ST_PRESSED);

endmodule

// File: tb/tb_key_scanner.sv
// Directed scoreboard bench for key_scanner with a
// behavioural 3x3 keypad matrix model.
module tb_key_scanner;
  import wam_pkg::*;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  key_scanner_if kp();

  key_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_FRAMES (3)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .kp     (kp.master)
  );

  logic [8:0] press = '0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_e;
  int         n_chk = 0;
  int         n_fail = 0;
  int         pulses = 0;
  int         pulse_cyc = 0;
  int         cyc;

  // A pressed key pulls its row low only while its column is strobed.
  always_comb begin
    kp.row_in = 3'b111;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (press[r*3+c] && !kp.col_out[c])
          kp.row_in[r] = 1'b0;
  end

  always @(posedge clk or negedge resetn)
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && kp.key_valid === 1'b1) begin
      pulses++;
      pulse_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(exp_q.size()), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_key", {28'd0, kp.key}, {28'd0, mon_e});
        check("pulse_held", {31'd0, kp.key_held}, 1);
      end
    end
  end

  task automatic wait_pulse(string name, int budget);
    int start = pulses;
    int k = 0;
    while (pulses == start && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, pulses > start}, 1);
  endtask

  task automatic wait_key(string name, logic [3:0] e, int budget);
    int k = 0;
    while (kp.key !== e && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, {28'd0, kp.key}, {28'd0, e});
  endtask

  logic [2:0] seq [4] = '{3'b110, 3'b101, 3'b011, 3'b110};
  int p0;
  int t_steady;

  initial begin
    resetn = 1'b0;
    press  = '0;
    repeat (3) @(negedge clk);
    check("rst_col", {29'd0, kp.col_out}, 32'h6);
    check("rst_key", {28'd0, kp.key}, 32'hF);
    check("rst_valid", {31'd0, kp.key_valid}, 0);
    check("rst_held", {31'd0, kp.key_held}, 0);

    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("col_seq", {29'd0, kp.col_out}, {29'd0, seq[k]});
      repeat (4) @(posedge clk);
      @(negedge clk);
    end
    repeat (60) @(negedge clk);
    check("idle_key", {28'd0, kp.key}, 32'hF);
    check("idle_no_pulse", pulses, 0);

    exp_q.push_back(4'b0110);
    press[5] = 1'b1;
    wait_pulse("press_pulse", 60);
    repeat (2) @(negedge clk);
    check("press_key", {28'd0, kp.key}, 32'h6);
    check("press_held", {31'd0, kp.key_held}, 1);
    p0 = pulses;
    repeat (60) @(negedge clk);
    check("no_repulse", pulses, p0);
    check("hold_key", {28'd0, kp.key}, 32'h6);

    press = '0;
    wait_key("release_key", 4'hF, 60);
    check("release_held", {31'd0, kp.key_held}, 0);

    press[0] = 1'b1;
    press[8] = 1'b1;
    repeat (72) @(negedge clk);
    check("multi_key", {28'd0, kp.key}, 32'hF);
    exp_q.push_back(4'b0000);
    press[8] = 1'b0;
    wait_pulse("single_pulse", 60);
    repeat (2) @(negedge clk);
    check("single_key", {28'd0, kp.key}, 32'h0);
    press = '0;
    wait_key("release2_key", 4'hF, 60);

    while ((cyc % 12) != 0) @(negedge clk);
    exp_q.push_back(4'b0101);
    for (int ph = 0; ph < 7; ph++) begin
      press[4] = (ph % 2 == 0);
      repeat (5) @(negedge clk);
    end
    press[4] = 1'b1;
    t_steady = cyc;
    p0 = pulses;
    wait_pulse("bounce_pulse", 60);
    check("bounce_delay", {31'd0, (pulse_cyc - t_steady) >= 24}, 1);
    repeat (60) @(negedge clk);
    check("bounce_once", pulses, p0 + 1);

    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("mid_rst_key", {28'd0, kp.key}, 32'hF);
    check("mid_rst_col", {29'd0, kp.col_out}, 32'h6);
    check("mid_rst_held", {31'd0, kp.key_held}, 0);
    @(negedge clk);
    exp_q.push_back(4'b0101);
    resetn = 1'b1;
    wait_pulse("recommit_pulse", 60);
    press = '0;
    wait_key("final_release", 4'hF, 60);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
